mon_host: RTL and testbench

- Initiator side of the monitor serial protocol: frames load/dump/exec commands into UART byte transmits and checks the per-byte echo the monitor returns.
- Delivers dump payload bytes to the local client.
- Sits between a local command source (bring-up sequencer, second board, or bench) and a uart instance whose rx/tx cross to the monitor.
- Runs strictly lock-step: the next byte is sent only after the previous byte's echo arrives.

---
 rtl/mon_host.sv | 206 ++++++++++++++++++++
 tb/tb_mon_host.sv | 436 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mon_host.sv
// Initiator side of the monitor serial protocol: frames load/dump/exec commands
// into lock-step UART byte transmits, checks each echo, and returns dump bytes.
module mon_host #(
  parameter logic [15:0] TX_GAP       = 16'hfff,
  parameter logic [23:0] ECHO_TIMEOUT = 24'hffffff
) (
  input  logic        CLK,
  input  logic        reset,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [1:0]  cmd_op,
  input  logic [15:0] cmd_addr,
  input  logic [15:0] cmd_len,
  input  logic [7:0]  wr_data,
  input  logic        wr_valid,
  output logic        wr_ready,
  output logic [7:0]  rd_data,
  output logic        rd_valid,
  output logic [7:0]  tx_byte,
  output logic        tx_transmit,
  input  logic        tx_busy,
  input  logic [7:0]  rx_byte,
  input  logic        rx_received,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [1:0]  err_code
);

  typedef enum logic [2:0] {
    IDLE, HDR_SEND, HDR_ECHO, LD_FETCH, LD_SEND, LD_ECHO, DP_RECV, DONE_ST
  } state_t;

  state_t      state;
  logic [1:0]  op_q;
  logic [15:0] addr_q;
  logic [15:0] len_q;
  logic [15:0] remaining;
  logic [2:0]  idx;
  logic [15:0] gap;
  logic [23:0] tmo;
  logic        can_send;

  function automatic logic [7:0] hdr_byte(input logic [2:0] i, input logic [1:0] op,
                                          input logic [15:0] addr, input logic [15:0] len);
    case (i)
      3'd0:    return {6'b0, op};
      3'd1:    return 8'h00;
      3'd2:    return addr[15:8];
      3'd3:    return addr[7:0];
      3'd4:    return len[15:8];
      default: return len[7:0];
    endcase
  endfunction

  assign cmd_ready = (state == IDLE);
  assign busy      = (state != IDLE);
  assign can_send  = !tx_busy && (gap == 16'd0);

  always_ff @(posedge CLK) begin
    if (!reset) begin
      state       <= IDLE;
      op_q        <= 2'd0;
      addr_q      <= 16'd0;
      len_q       <= 16'd0;
      remaining   <= 16'd0;
      idx         <= 3'd0;
      gap         <= 16'd0;
      tmo         <= 24'd0;
      tx_byte     <= 8'd0;
      tx_transmit <= 1'b0;
      rd_data     <= 8'd0;
      rd_valid    <= 1'b0;
      wr_ready    <= 1'b0;
      done        <= 1'b0;
      err         <= 1'b0;
      err_code    <= 2'd0;
    end else begin
      tx_transmit <= 1'b0;
      rd_valid    <= 1'b0;
      done        <= 1'b0;
      err         <= 1'b0;
      // Gap keeps counting across commands so back-to-back frames stay spaced
      if (gap != 16'd0) gap <= gap - 16'd1;

      case (state)
        IDLE: begin
          if (cmd_valid) begin
            op_q      <= cmd_op;
            addr_q    <= cmd_addr;
            len_q     <= cmd_len;
            remaining <= cmd_len;
            idx       <= 3'd0;
            err_code  <= 2'd0;
            state     <= HDR_SEND;
          end
        end

        HDR_SEND: begin
          if (can_send) begin
            tx_byte     <= hdr_byte(idx, op_q, addr_q, len_q);
            tx_transmit <= 1'b1;
            gap         <= TX_GAP;
            tmo         <= ECHO_TIMEOUT;
            state       <= HDR_ECHO;
          end
        end

        HDR_ECHO: begin
          if (rx_received) begin
            if (rx_byte != tx_byte) begin
              err      <= 1'b1;
              err_code <= 2'd1;
              state    <= IDLE;
            end else if (idx == 3'd5) begin
              case (op_q)
                2'd1:    state <= LD_FETCH;
                2'd2: begin
                  tmo   <= ECHO_TIMEOUT;
                  state <= DP_RECV;
                end
                default: state <= DONE_ST;
              endcase
            end else begin
              idx   <= idx + 3'd1;
              state <= HDR_SEND;
            end
          end else if (tmo <= 24'd1) begin
            err      <= 1'b1;
            err_code <= 2'd2;
            state    <= IDLE;
          end else begin
            tmo <= tmo - 24'd1;
          end
        end

        LD_FETCH: begin
          if (remaining == 16'd0) begin
            wr_ready <= 1'b0;
            state    <= DONE_ST;
          end else if (wr_valid && wr_ready) begin
            tx_byte  <= wr_data;
            wr_ready <= 1'b0;
            state    <= LD_SEND;
          end else begin
            wr_ready <= 1'b1;
          end
        end

        LD_SEND: begin
          if (can_send) begin
            tx_transmit <= 1'b1;
            gap         <= TX_GAP;
            tmo         <= ECHO_TIMEOUT;
            state       <= LD_ECHO;
          end
        end

        LD_ECHO: begin
          if (rx_received) begin
            if (rx_byte == tx_byte) begin
              remaining <= remaining - 16'd1;
              state     <= LD_FETCH;
            end else begin
              err      <= 1'b1;
              err_code <= 2'd1;
              state    <= IDLE;
            end
          end else if (tmo <= 24'd1) begin
            err      <= 1'b1;
            err_code <= 2'd2;
            state    <= IDLE;
          end else begin
            tmo <= tmo - 24'd1;
          end
        end

        DP_RECV: begin
          if (remaining == 16'd0) begin
            state <= DONE_ST;
          end else if (rx_received) begin
            // Dump payload is forwarded as-is; the monitor does not echo it
            rd_data   <= rx_byte;
            rd_valid  <= 1'b1;
            remaining <= remaining - 16'd1;
            tmo       <= ECHO_TIMEOUT;
          end else if (tmo <= 24'd1) begin
            err      <= 1'b1;
            err_code <= 2'd2;
            state    <= IDLE;
          end else begin
            tmo <= tmo - 24'd1;
          end
        end

        DONE_ST: begin
          done  <= 1'b1;
          state <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mon_host.sv
// Directed bench for mon_host: an echoing monitor model answers every transmit,
// and each scenario task checks the frames, strobes and error reporting.
module tb_mon_host;
  localparam logic [15:0] GAP = 16'd4;
  localparam logic [23:0] TMO = 24'd100;

  logic        CLK, reset;
  logic        cmd_valid, cmd_ready;
  logic [1:0]  cmd_op;
  logic [15:0] cmd_addr, cmd_len;
  logic [7:0]  wr_data;
  logic        wr_valid, wr_ready;
  logic [7:0]  rd_data;
  logic        rd_valid;
  logic [7:0]  tx_byte;
  logic        tx_transmit, tx_busy;
  logic [7:0]  rx_byte;
  logic        rx_received;
  logic        busy, done, err;
  logic [1:0]  err_code;

  mon_host #(.TX_GAP(GAP), .ECHO_TIMEOUT(TMO)) dut (
    .CLK(CLK), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_addr(cmd_addr), .cmd_len(cmd_len),
    .wr_data(wr_data), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .rd_data(rd_data), .rd_valid(rd_valid),
    .tx_byte(tx_byte), .tx_transmit(tx_transmit), .tx_busy(tx_busy),
    .rx_byte(rx_byte), .rx_received(rx_received),
    .busy(busy), .done(done), .err(err), .err_code(err_code)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int tests = 0;
  int fails = 0;

  // Observation log, written only by the logger process
  int         cyc = 0;
  int         tx_n = 0;
  logic [7:0] tx_log [512];
  int         tx_cyc [512];
  int         rd_n = 0;
  logic [7:0] rd_log [64];
  int         done_n = 0;
  int         err_n = 0;
  int         err_cyc = 0;
  logic [1:0] err_code_at = 2'd0;
  int         wr_rdy_n = 0;

  initial begin
    forever begin
      @(negedge CLK);
      cyc++;
      if (tx_transmit && tx_n < 512) begin
        tx_log[tx_n] = tx_byte;
        tx_cyc[tx_n] = cyc;
        tx_n++;
      end
      if (rd_valid && rd_n < 64) begin
        rd_log[rd_n] = rd_data;
        rd_n++;
      end
      if (done) done_n++;
      if (err) begin
        err_n++;
        err_cyc = cyc;
        err_code_at = err_code;
      end
      if (wr_ready) wr_rdy_n++;
    end
  end

  // Monitor model: echoes each transmitted byte, optionally corrupts one,
  // and streams dump bytes after the last header echo
  bit         echo_on = 1'b1;
  int         corrupt_at = -1;
  int         dump_n = 0;
  logic [7:0] dump_b [4];
  int         rcnt = 0;
  int         resp_k = 0;
  logic [7:0] resp_b;

  initial begin
    rx_received = 1'b0;
    rx_byte = 8'h00;
    forever begin
      @(negedge CLK);
      if (cmd_valid && cmd_ready) rcnt = 0;
      if (tx_transmit) begin
        resp_b = tx_byte;
        if (rcnt == corrupt_at) resp_b = 8'hFF;
        resp_k = rcnt;
        rcnt++;
        if (echo_on) begin
          @(negedge CLK);
          rx_byte = resp_b;
          rx_received = 1'b1;
          @(negedge CLK);
          rx_received = 1'b0;
          if (resp_k == 5 && dump_n > 0) begin
            for (int k = 0; k < dump_n; k++) begin
              @(negedge CLK);
              @(negedge CLK);
              rx_byte = dump_b[k];
              rx_received = 1'b1;
              @(negedge CLK);
              rx_received = 1'b0;
            end
          end
        end
      end
    end
  end

  logic [7:0] pl [4];

  task automatic send_cmd(input logic [1:0] op, input logic [15:0] addr, input logic [15:0] len);
    bit rdy;
    rdy = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(posedge CLK);
      #1;
      if (cmd_ready) begin
        rdy = 1'b1;
        break;
      end
    end
    tests++;
    if (!rdy) begin
      fails++;
      $display("FAIL cmd_ready_wait: cmd_ready=%b required 1", cmd_ready);
    end
    cmd_op = op;
    cmd_addr = addr;
    cmd_len = len;
    cmd_valid = 1'b1;
    @(posedge CLK);
    #1;
    cmd_valid = 1'b0;
  endtask

  task automatic wait_end(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge CLK);
      if (done || err) begin
        ok = 1'b1;
        break;
      end
    end
    @(negedge CLK);
  endtask

  // Feeds n payload bytes; if rst_tx>0, pulls reset low when that transmit is seen
  task automatic drive_load(input int n, input int rst_tx, output int hs, output bit ok);
    int k, txc;
    k = 0; txc = 0; hs = 0; ok = 1'b0;
    wr_data = pl[0];
    wr_valid = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      @(negedge CLK);
      if (tx_transmit) txc++;
      if (rst_tx > 0 && txc == rst_tx) begin
        reset = 1'b0;
        ok = 1'b1;
        break;
      end
      if (done || err) begin
        ok = 1'b1;
        break;
      end
      if (wr_valid && wr_ready) begin
        hs++;
        k++;
        @(posedge CLK);
        #1;
        if (k < n) wr_data = pl[k];
        else wr_valid = 1'b0;
      end
    end
    wr_valid = 1'b0;
    if (rst_tx == 0) @(negedge CLK);
  endtask

  task automatic test_reset;
    reset = 1'b0;
    repeat (3) @(posedge CLK);
    #1;
    tests++;
    if ({busy, wr_ready, tx_transmit, rd_valid, done, err} !== 6'b0) begin
      fails++;
      $display("FAIL reset_ctrl: busy/wr_ready/strobes=%b required 000000",
               {busy, wr_ready, tx_transmit, rd_valid, done, err});
    end
    tests++;
    if ({cmd_ready, err_code, tx_byte, rd_data} !== {1'b1, 2'd0, 8'd0, 8'd0}) begin
      fails++;
      $display("FAIL reset_data: cmd_ready=%b err_code=%0d tx_byte=%h rd_data=%h required 1 0 00 00",
               cmd_ready, err_code, tx_byte, rd_data);
    end
    reset = 1'b1;
    @(negedge CLK);
  endtask

  task automatic test_load;
    logic [7:0] exp [9];
    int b0, d0, e0, hs, mind;
    bit ok;
    exp = '{8'h01, 8'h00, 8'h00, 8'h10, 8'h00, 8'h03, 8'hA1, 8'hB2, 8'hC3};
    b0 = tx_n; d0 = done_n; e0 = err_n;
    pl[0] = 8'hA1; pl[1] = 8'hB2; pl[2] = 8'hC3;
    send_cmd(2'd1, 16'h0010, 16'd3);
    drive_load(3, 0, hs, ok);
    @(negedge CLK);
    tests++;
    if (!ok || tx_n - b0 != 9) begin
      fails++;
      $display("FAIL load_count: finished=%b tx=%0d required 1 9", ok, tx_n - b0);
    end
    for (int i = 0; i < 9; i++) begin
      tests++;
      if (tx_log[b0 + i] !== exp[i]) begin
        fails++;
        $display("FAIL load_tx%0d: got %h required %h", i, tx_log[b0 + i], exp[i]);
      end
    end
    tests++;
    if (hs != 3) begin
      fails++;
      $display("FAIL load_handshakes: got %0d required 3", hs);
    end
    tests++;
    if (done_n - d0 != 1 || err_n != e0) begin
      fails++;
      $display("FAIL load_done: done=%0d err=%0d required 1 0", done_n - d0, err_n - e0);
    end
    mind = 1000;
    for (int i = 1; i < 9; i++)
      if (tx_cyc[b0 + i] - tx_cyc[b0 + i - 1] < mind) mind = tx_cyc[b0 + i] - tx_cyc[b0 + i - 1];
    tests++;
    if (mind < int'(GAP) + 1) begin
      fails++;
      $display("FAIL load_gap: min spacing %0d required >= %0d", mind, int'(GAP) + 1);
    end
  endtask

  task automatic test_dump;
    logic [7:0] exp [6];
    int b0, r0, d0, e0;
    bit ok;
    exp = '{8'h02, 8'h00, 8'h01, 8'h00, 8'h00, 8'h02};
    b0 = tx_n; r0 = rd_n; d0 = done_n; e0 = err_n;
    dump_b[0] = 8'h5A; dump_b[1] = 8'h7E; dump_n = 2;
    send_cmd(2'd2, 16'h0100, 16'd2);
    wait_end(2000, ok);
    dump_n = 0;
    tests++;
    if (!ok || tx_n - b0 != 6) begin
      fails++;
      $display("FAIL dump_count: finished=%b tx=%0d required 1 6", ok, tx_n - b0);
    end
    for (int i = 0; i < 6; i++) begin
      tests++;
      if (tx_log[b0 + i] !== exp[i]) begin
        fails++;
        $display("FAIL dump_tx%0d: got %h required %h", i, tx_log[b0 + i], exp[i]);
      end
    end
    tests++;
    if (rd_n - r0 != 2 || rd_log[r0] !== 8'h5A || rd_log[r0 + 1] !== 8'h7E) begin
      fails++;
      $display("FAIL dump_rd: count=%0d bytes=%h %h required 2 5a 7e",
               rd_n - r0, rd_log[r0], rd_log[r0 + 1]);
    end
    tests++;
    if (done_n - d0 != 1 || err_n != e0) begin
      fails++;
      $display("FAIL dump_done: done=%0d err=%0d required 1 0", done_n - d0, err_n - e0);
    end
  endtask

  task automatic test_exec;
    logic [7:0] exp [6];
    int b0, d0, w0;
    bit ok;
    exp = '{8'h03, 8'h00, 8'h00, 8'h00, 8'h12, 8'h34};
    b0 = tx_n; d0 = done_n; w0 = wr_rdy_n;
    send_cmd(2'd3, 16'h0000, 16'h1234);
    wait_end(2000, ok);
    tests++;
    if (!ok || tx_n - b0 != 6) begin
      fails++;
      $display("FAIL exec_count: finished=%b tx=%0d required 1 6", ok, tx_n - b0);
    end
    for (int i = 0; i < 6; i++) begin
      tests++;
      if (tx_log[b0 + i] !== exp[i]) begin
        fails++;
        $display("FAIL exec_tx%0d: got %h required %h", i, tx_log[b0 + i], exp[i]);
      end
    end
    tests++;
    if (done_n - d0 != 1 || wr_rdy_n != w0) begin
      fails++;
      $display("FAIL exec_done: done=%0d wr_ready_cycles=%0d required 1 0", done_n - d0, wr_rdy_n - w0);
    end
  endtask

  task automatic test_mismatch;
    int b0, d0, e0;
    bit ok;
    b0 = tx_n; d0 = done_n; e0 = err_n;
    corrupt_at = 2;
    send_cmd(2'd3, 16'hABCD, 16'd1);
    wait_end(2000, ok);
    tests++;
    if (!ok || err_n - e0 != 1 || err_code_at !== 2'd1) begin
      fails++;
      $display("FAIL mismatch_err: err=%0d err_code=%0d required 1 1", err_n - e0, err_code_at);
    end
    tests++;
    if (cmd_ready !== 1'b1) begin
      fails++;
      $display("FAIL mismatch_ready: cmd_ready=%b required 1", cmd_ready);
    end
    repeat (30) @(negedge CLK);
    corrupt_at = -1;
    tests++;
    if (tx_n - b0 != 3 || done_n != d0) begin
      fails++;
      $display("FAIL mismatch_stop: tx=%0d done=%0d required 3 0", tx_n - b0, done_n - d0);
    end
    tests++;
    if (err_code !== 2'd1) begin
      fails++;
      $display("FAIL mismatch_hold: err_code=%0d required 1", err_code);
    end
  endtask

  task automatic test_dump_len0;
    int b0, r0, d0;
    bit ok;
    b0 = tx_n; r0 = rd_n; d0 = done_n;
    send_cmd(2'd2, 16'h0200, 16'd0);
    tests++;
    if (err_code !== 2'd0) begin
      fails++;
      $display("FAIL accept_clears_err: err_code=%0d required 0", err_code);
    end
    wait_end(2000, ok);
    tests++;
    if (!ok || done_n - d0 != 1 || tx_n - b0 != 6 || rd_n != r0) begin
      fails++;
      $display("FAIL dump_len0: done=%0d tx=%0d rd=%0d required 1 6 0",
               done_n - d0, tx_n - b0, rd_n - r0);
    end
  endtask

  task automatic test_timeout;
    int b0, e0;
    bit ok;
    b0 = tx_n; e0 = err_n;
    echo_on = 1'b0;
    send_cmd(2'd3, 16'h0000, 16'd1);
    wait_end(400, ok);
    echo_on = 1'b1;
    tests++;
    if (!ok || err_n - e0 != 1 || err_code_at !== 2'd2) begin
      fails++;
      $display("FAIL timeout_err: err=%0d err_code=%0d required 1 2", err_n - e0, err_code_at);
    end
    tests++;
    if (tx_n - b0 != 1 || err_cyc - tx_cyc[b0] != int'(TMO)) begin
      fails++;
      $display("FAIL timeout_delay: tx=%0d cycles=%0d required 1 %0d",
               tx_n - b0, err_cyc - tx_cyc[b0], int'(TMO));
    end
  endtask

  task automatic test_reset_mid;
    logic [7:0] exp [7];
    int b0, d0, e0, hs;
    bit ok;
    exp = '{8'h01, 8'h00, 8'h00, 8'h20, 8'h00, 8'h01, 8'h77};
    pl[0] = 8'hA1; pl[1] = 8'hB2; pl[2] = 8'hC3;
    send_cmd(2'd1, 16'h0010, 16'd3);
    drive_load(3, 8, hs, ok);
    @(posedge CLK);
    #1;
    tests++;
    if (!ok || {busy, wr_ready, tx_transmit, rd_valid, done, err} !== 6'b0 || err_code !== 2'd0) begin
      fails++;
      $display("FAIL reset_mid: reached=%b busy/wr_ready/strobes=%b err_code=%0d required 1 000000 0",
               ok, {busy, wr_ready, tx_transmit, rd_valid, done, err}, err_code);
    end
    reset = 1'b1;
    repeat (6) @(negedge CLK);
    b0 = tx_n; d0 = done_n; e0 = err_n;
    pl[0] = 8'h77;
    send_cmd(2'd1, 16'h0020, 16'd1);
    drive_load(1, 0, hs, ok);
    @(negedge CLK);
    tests++;
    if (!ok || done_n - d0 != 1 || err_n != e0 || tx_n - b0 != 7 || hs != 1) begin
      fails++;
      $display("FAIL after_reset: done=%0d err=%0d tx=%0d hs=%0d required 1 0 7 1",
               done_n - d0, err_n - e0, tx_n - b0, hs);
    end
    for (int i = 0; i < 7; i++) begin
      tests++;
      if (tx_log[b0 + i] !== exp[i]) begin
        fails++;
        $display("FAIL after_reset_tx%0d: got %h required %h", i, tx_log[b0 + i], exp[i]);
      end
    end
  endtask

  initial begin
    reset = 1'b0;
    cmd_valid = 1'b0; cmd_op = 2'd0; cmd_addr = 16'd0; cmd_len = 16'd0;
    wr_data = 8'd0; wr_valid = 1'b0; tx_busy = 1'b0;
    test_reset;
    test_load;
    test_dump;
    test_exec;
    test_mismatch;
    test_dump_len0;
    test_timeout;
    test_reset_mid;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
